mem_wb_stage: RTL and testbench

- Memory stage of the 5-stage MIPS-32 pipeline. Consumes the registered outputs of the EX/MEM pipeline register: addPcOut, aluResultOut, readData2Out, muxInstOut, zeroOut, WBOut and MEMOut.
- Contains the word-addressed data memory, resolves branches (pcSrc, branch target back to IF), and holds the MEM/WB pipeline register that feeds the writeback mux.
- Supports hold (stall) and flush (bubble insertion) from the hazard unit.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mem_wb_stage_if.sv | 34 +++
 rtl/data_memory.sv | 24 ++
 rtl/mem_wb_stage.sv | 70 +++++++
 tb/tb_mem_wb_stage.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline definitions: control-bit positions, datapath widths
// and the address-range helper used by the memory stage.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int MEM_BRANCH = 2;
   localparam int MEM_READ   = 1;
   localparam int MEM_WRITE  = 0;

   // Any bit set above the word-index field means the byte address lies past the array.
   function automatic logic is_out_of_range(input logic [DATA_W-1:0] addr, input int addr_w);
      return (addr >> (addr_w + 2)) != '0;
   endfunction

   function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of EX/MEM inputs, hazard controls and MEM/WB outputs for the memory stage.
// The stage itself takes the slave view; the driving pipeline takes the master view.
interface mem_wb_stage_if;
   import mips_pkg::*;

   logic [DATA_W-1:0] addPc;
   logic [DATA_W-1:0] aluResult;
   logic              zero;
   logic [DATA_W-1:0] readData2;
   logic [REG_W-1:0]  muxInst;
   logic [1:0]        WB;
   logic [2:0]        MEM;
   logic              hold;
   logic              flush;

   logic              pcSrc;
   logic [DATA_W-1:0] branchTarget;
   logic [DATA_W-1:0] readDataOut;
   logic [DATA_W-1:0] aluResultOut;
   logic [REG_W-1:0]  muxInstOut;
   logic [1:0]        WBOut;
   logic              memError;

   modport master (
      output addPc, aluResult, zero, readData2, muxInst, WB, MEM, hold, flush,
      input  pcSrc, branchTarget, readDataOut, aluResultOut, muxInstOut, WBOut, memError
   );

   modport slave (
      input  addPc, aluResult, zero, readData2, muxInst, WB, MEM, hold, flush,
      output pcSrc, branchTarget, readDataOut, aluResultOut, muxInstOut, WBOut, memError
   );

endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// A same-cycle read therefore sees the contents from before the write lands.
module data_memory #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS-32 memory stage: address decode and error check, branch resolution,
// data memory access and the MEM/WB pipeline register with hold/flush.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input logic           clock,
   input logic           reset,
   mem_wb_stage_if.slave bus
);

   logic [ADDR_W-1:0] word_idx;
   logic              misaligned;
   logic              out_of_range;
   logic              access;
   logic              illegal;
   logic              read_write_clash;
   logic              write_en;
   logic [DATA_W-1:0] mem_rdata;

   assign word_idx         = bus.aluResult[ADDR_W+1:2];
   assign misaligned       = is_misaligned(bus.aluResult);
   assign out_of_range     = is_out_of_range(bus.aluResult, ADDR_W);
   assign access           = bus.MEM[MEM_READ] | bus.MEM[MEM_WRITE];
   assign illegal          = access & (misaligned | out_of_range);
   assign read_write_clash = bus.MEM[MEM_READ] & bus.MEM[MEM_WRITE];

   // Reset gates the write so a store caught by a mid-cycle reset never commits.
   assign write_en = bus.MEM[MEM_WRITE] & ~illegal & ~bus.hold & ~bus.flush & ~reset;

   assign bus.pcSrc        = bus.MEM[MEM_BRANCH] & bus.zero;
   assign bus.branchTarget = bus.addPc;

   data_memory #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_memory (
      .clock (clock),
      .we    (write_en),
      .addr  (word_idx),
      .wdata (bus.readData2),
      .rdata (mem_rdata)
   );

   // Under hold only WBOut may change (flush still kills it); memError never
   // fires on a held cycle so the re-presented instruction reports only once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.readDataOut  <= '0;
         bus.aluResultOut <= '0;
         bus.muxInstOut   <= '0;
         bus.WBOut        <= '0;
         bus.memError     <= 1'b0;
      end else if (bus.hold) begin
         if (bus.flush) begin
            bus.WBOut <= '0;
         end
         bus.memError <= 1'b0;
      end else begin
         bus.readDataOut  <= (bus.MEM[MEM_READ] & ~illegal) ? mem_rdata : '0;
         bus.aluResultOut <= bus.aluResult;
         bus.muxInstOut   <= bus.muxInst;
         bus.WBOut        <= bus.flush ? 2'b00 : bus.WB;
         bus.memError     <= bus.flush ? 1'b0 : (illegal | read_write_clash);
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage: one vector per clock cycle,
// plus hand-written reset sequences at the start and end.
module tb_mem_wb_stage;

   logic clock;
   logic reset;
   int   error_count;
   int   check_count;

   mem_wb_stage_if bus ();

   mem_wb_stage #(
      .DEPTH  (256),
      .ADDR_W (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [2:0]  mem;
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        zero;
      logic [31:0] addpc;
      logic        hold;
      logic        flush;
      logic        chk_data;
      logic        e_pcsrc;
      logic [31:0] e_read;
      logic [31:0] e_alu;
      logic [4:0]  e_rd;
      logic [1:0]  e_wb;
      logic        e_err;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                                input logic [31:0] wdata, input logic [4:0] rd, input logic zero,
                                input logic [31:0] addpc, input logic hold, input logic flush);
      bus.MEM       = mem;
      bus.WB        = wb;
      bus.aluResult = alu;
      bus.readData2 = wdata;
      bus.muxInst   = rd;
      bus.zero      = zero;
      bus.addPc     = addpc;
      bus.hold      = hold;
      bus.flush     = flush;
   endtask

   task automatic checkRegsZero(input string tag);
      checkOutput({tag, " readDataOut"},  bus.readDataOut, 32'h0);
      checkOutput({tag, " aluResultOut"}, bus.aluResultOut, 32'h0);
      checkOutput({tag, " muxInstOut"},   {27'h0, bus.muxInstOut}, 32'h0);
      checkOutput({tag, " WBOut"},        {30'h0, bus.WBOut}, 32'h0);
      checkOutput({tag, " memError"},     {31'h0, bus.memError}, 32'h0);
   endtask

   initial begin
      error_count = 0;
      check_count = 0;

      //            mem     wb     alu          wdata         rd     z     addpc        hold  flush chk   pcs   e_read        e_alu        e_rd   e_wb   e_err
      vecs[0]  = '{3'b001, 2'b00, 32'h10,      32'hDEADBEEF, 5'd0,  1'b0, 32'h100,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h10,      5'd0,  2'b00, 1'b0};
      vecs[1]  = '{3'b010, 2'b11, 32'h10,      32'h0,        5'd5,  1'b0, 32'h104,     1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10,      5'd5,  2'b11, 1'b0};
      vecs[2]  = '{3'b100, 2'b00, 32'h0,       32'h0,        5'd0,  1'b1, 32'h40,      1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,       5'd0,  2'b00, 1'b0};
      vecs[3]  = '{3'b100, 2'b00, 32'h0,       32'h0,        5'd0,  1'b0, 32'h40,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,       5'd0,  2'b00, 1'b0};
      vecs[4]  = '{3'b001, 2'b00, 32'h12,      32'h55555555, 5'd0,  1'b0, 32'h110,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12,      5'd0,  2'b00, 1'b1};
      vecs[5]  = '{3'b010, 2'b11, 32'h10,      32'h0,        5'd3,  1'b0, 32'h114,     1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10,      5'd3,  2'b11, 1'b0};
      vecs[6]  = '{3'b010, 2'b11, 32'h400,     32'h0,        5'd7,  1'b0, 32'h118,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h400,     5'd7,  2'b11, 1'b1};
      vecs[7]  = '{3'b001, 2'b01, 32'h10,      32'hCAFEF00D, 5'd9,  1'b0, 32'h11C,     1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h400,     5'd7,  2'b11, 1'b0};
      vecs[8]  = '{3'b010, 2'b10, 32'h10,      32'h0,        5'd2,  1'b0, 32'h120,     1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h10,      5'd2,  2'b10, 1'b0};
      vecs[9]  = '{3'b001, 2'b00, 32'h14,      32'h0BADF00D, 5'd0,  1'b0, 32'h124,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h14,      5'd0,  2'b00, 1'b0};
      vecs[10] = '{3'b001, 2'b11, 32'h14,      32'hAAAA0001, 5'd4,  1'b0, 32'h128,     1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,       5'd0,  2'b00, 1'b0};
      vecs[11] = '{3'b010, 2'b11, 32'h14,      32'h0,        5'd6,  1'b0, 32'h12C,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0BADF00D, 32'h14,      5'd6,  2'b11, 1'b0};
      vecs[12] = '{3'b010, 2'b11, 32'h10,      32'h0,        5'd1,  1'b0, 32'h130,     1'b1, 1'b1, 1'b1, 1'b0, 32'h0BADF00D, 32'h14,      5'd6,  2'b00, 1'b0};
      vecs[13] = '{3'b001, 2'b00, 32'h8,       32'h11,       5'd0,  1'b0, 32'h134,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h8,       5'd0,  2'b00, 1'b0};
      vecs[14] = '{3'b011, 2'b11, 32'h8,       32'h22,       5'd8,  1'b0, 32'h138,     1'b0, 1'b0, 1'b1, 1'b0, 32'h11,       32'h8,       5'd8,  2'b11, 1'b1};
      vecs[15] = '{3'b010, 2'b11, 32'h8,       32'h0,        5'd8,  1'b0, 32'h13C,     1'b0, 1'b0, 1'b1, 1'b0, 32'h22,       32'h8,       5'd8,  2'b11, 1'b0};
      vecs[16] = '{3'b001, 2'b00, 32'h3FC,     32'h7777,     5'd0,  1'b0, 32'h140,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h3FC,     5'd0,  2'b00, 1'b0};
      vecs[17] = '{3'b010, 2'b11, 32'h3FC,     32'h0,        5'd31, 1'b0, 32'h144,     1'b0, 1'b0, 1'b1, 1'b0, 32'h7777,     32'h3FC,     5'd31, 2'b11, 1'b0};
      vecs[18] = '{3'b000, 2'b10, 32'h403,     32'h0,        5'd12, 1'b1, 32'h148,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h403,     5'd12, 2'b10, 1'b0};

      // Reset state; branch outputs must stay live while reset is asserted.
      reset = 1'b1;
      applyStimulus(3'b100, 2'b11, 32'h0, 32'h0, 5'd0, 1'b1, 32'h80, 1'b0, 1'b0);
      #1;
      checkRegsZero("reset");
      checkOutput("reset pcSrc", {31'h0, bus.pcSrc}, 32'h1);
      checkOutput("reset branchTarget", bus.branchTarget, 32'h80);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].mem, vecs[i].wb, vecs[i].alu, vecs[i].wdata, vecs[i].rd,
                       vecs[i].zero, vecs[i].addpc, vecs[i].hold, vecs[i].flush);
         #1;
         checkOutput($sformatf("v%0d pcSrc", i), {31'h0, bus.pcSrc}, {31'h0, vecs[i].e_pcsrc});
         checkOutput($sformatf("v%0d branchTarget", i), bus.branchTarget, vecs[i].addpc);
         @(posedge clock);
         #1;
         if (vecs[i].chk_data) begin
            checkOutput($sformatf("v%0d readDataOut", i), bus.readDataOut, vecs[i].e_read);
            checkOutput($sformatf("v%0d aluResultOut", i), bus.aluResultOut, vecs[i].e_alu);
            checkOutput($sformatf("v%0d muxInstOut", i), {27'h0, bus.muxInstOut}, {27'h0, vecs[i].e_rd});
         end
         checkOutput($sformatf("v%0d WBOut", i), {30'h0, bus.WBOut}, {30'h0, vecs[i].e_wb});
         checkOutput($sformatf("v%0d memError", i), {31'h0, bus.memError}, {31'h0, vecs[i].e_err});
      end

      // Mid-cycle async reset with a store in flight: outputs clear before any edge.
      applyStimulus(3'b001, 2'b11, 32'h10, 32'h99999999, 5'd5, 1'b0, 32'h200, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkRegsZero("async reset");
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(3'b010, 2'b11, 32'h10, 32'h0, 5'd5, 1'b0, 32'h204, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      checkOutput("post-reset load readDataOut", bus.readDataOut, 32'hDEADBEEF);
      checkOutput("post-reset load WBOut", {30'h0, bus.WBOut}, 32'h3);
      checkOutput("post-reset load memError", {31'h0, bus.memError}, 32'h0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
